// File: rtl/gather_queue_if.sv
// Handshake bundle between the gather stage, the gather_queue and its consumer.
// The master modport is the producer/consumer side; the slave modport is the queue.
interface gather_queue_if #(
  parameter int DATA  = 32,
  parameter int IN    = 8,
  parameter int OUT   = 4,
  parameter int DEPTH = 16
);
  localparam int CNT = $clog2(DEPTH) + 1;

  logic [IN-1:0]            wr_valid;
  logic [IN-1:0][DATA-1:0]  wr_data;
  logic                     wr_ready;
  logic [OUT-1:0]           rd_valid;
  logic [OUT-1:0][DATA-1:0] rd_data;
  logic [OUT-1:0]           rd_ack;
  logic [CNT-1:0]           count;
  logic                     full;
  logic                     empty;

  modport master (
    output wr_valid, wr_data, rd_ack,
    input  wr_ready, rd_valid, rd_data, count, full, empty
  );

  modport slave (
    input  wr_valid, wr_data, rd_ack,
    output wr_ready, rd_valid, rd_data, count, full, empty
  );
endinterface

// File: rtl/gather_queue.sv
// Multi-lane FIFO: accepts a contiguous group of up to IN entries per cycle and
// presents the OUT oldest entries in parallel; the consumer retires any prefix.
module gather_queue #(
  parameter int   DATA  = 32,
  parameter int   IN    = 8,
  parameter int   OUT   = 4,
  parameter int   DEPTH = 16,
  parameter logic ACT   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  gather_queue_if.slave q
);
  localparam int PTR = $clog2(DEPTH);
  localparam int CNT = $clog2(DEPTH) + 1;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < IN) || (OUT > DEPTH)) begin : g_bad_params
    $error("gather_queue: DEPTH must be a power of two with DEPTH >= IN and DEPTH >= OUT");
  end

  logic [DEPTH-1:0][DATA-1:0] mem_q, mem_d;
  logic [PTR-1:0]             rp_q, rp_d;
  logic [PTR-1:0]             wp_q, wp_d;
  logic [CNT-1:0]             count_q, count_d;

  logic [IN-1:0]  wr_v;
  logic [OUT-1:0] rd_ack_i;
  logic [OUT-1:0] rd_v;
  logic [OUT-1:0] ack_eff;
  logic [CNT-1:0] nw;
  logic [CNT-1:0] nr;
  logic [CNT-1:0] free_slots;
  logic           wr_ready_i;
  logic           wr_fire;

  // Readiness looks only at registered occupancy, so same-cycle pops never make room.
  always_comb begin
    wr_v       = ACT ? q.wr_valid : ~q.wr_valid;
    rd_ack_i   = ACT ? q.rd_ack : ~q.rd_ack;
    free_slots = CNT'(DEPTH) - count_q;
    wr_ready_i = free_slots >= CNT'(IN);

    nw = '0;
    for (int i = 0; i < IN; i++) begin
      nw = nw + CNT'(wr_v[i]);
    end
    wr_fire = wr_ready_i && (nw != '0);

    for (int j = 0; j < OUT; j++) begin
      rd_v[j] = CNT'(j) < count_q;
    end
    ack_eff = rd_ack_i & rd_v;

    nr = '0;
    for (int j = 0; j < OUT; j++) begin
      nr = nr + CNT'(ack_eff[j]);
    end

    mem_d = mem_q;
    if (wr_fire) begin
      for (int i = 0; i < IN; i++) begin
        if (CNT'(i) < nw) begin
          mem_d[wp_q + PTR'(i)] = q.wr_data[i];
        end
      end
    end

    wp_d    = wr_fire ? wp_q + PTR'(nw) : wp_q;
    rp_d    = rp_q + PTR'(nr);
    count_d = count_q + (wr_fire ? nw : '0) - nr;
  end

  always_comb begin
    for (int j = 0; j < OUT; j++) begin
      q.rd_data[j] = mem_q[rp_q + PTR'(j)];
    end
    q.rd_valid = ACT ? rd_v : ~rd_v;
    q.wr_ready = ACT ? wr_ready_i : ~wr_ready_i;
    q.count    = count_q;
    q.full     = count_q == CNT'(DEPTH);
    q.empty    = count_q == '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  wr_valid_contiguous: assert property (@(posedge clk) disable iff (reset)
    ((wr_v & (wr_v + IN'(1))) == '0))
    else $error("gather_queue: wr_valid is not contiguous from lane 0");

  rd_ack_prefix: assert property (@(posedge clk) disable iff (reset)
    ((ack_eff & (ack_eff + OUT'(1))) == '0))
    else $error("gather_queue: rd_ack is not a prefix of rd_valid");
endmodule

// File: tb/tb_gather_queue.sv
// Directed, table-driven bench for gather_queue with hand-computed expectations,
// plus hand-written reset sequences.
module tb_gather_queue;
  localparam int DATA  = 32;
  localparam int IN    = 8;
  localparam int OUT   = 4;
  localparam int DEPTH = 16;
  localparam int NVEC  = 17;

  typedef struct packed {
    logic [IN-1:0]            wr_valid;
    logic [DATA-1:0]          base;
    logic [OUT-1:0]           ack;
    logic [4:0]               cnt;
    logic [OUT-1:0]           rdv;
    logic                     rdy;
    logic                     full;
    logic                     empty;
    logic [OUT-1:0][DATA-1:0] d;
  } vec_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  vec_t vecs [NVEC];

  gather_queue_if #(.DATA(DATA), .IN(IN), .OUT(OUT), .DEPTH(DEPTH)) q_if ();

  gather_queue #(.DATA(DATA), .IN(IN), .OUT(OUT), .DEPTH(DEPTH), .ACT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (q_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [IN-1:0] wv, input logic [DATA-1:0] base,
                              input logic [OUT-1:0] ack, input logic [4:0] cnt,
                              input logic [OUT-1:0] rdv, input logic rdy,
                              input logic full, input logic empty,
                              input logic [DATA-1:0] d0, input logic [DATA-1:0] d1,
                              input logic [DATA-1:0] d2, input logic [DATA-1:0] d3);
    vec_t v;
    v.wr_valid = wv;
    v.base     = base;
    v.ack      = ack;
    v.cnt      = cnt;
    v.rdv      = rdv;
    v.rdy      = rdy;
    v.full     = full;
    v.empty    = empty;
    v.d[0]     = d0;
    v.d[1]     = d1;
    v.d[2]     = d2;
    v.d[3]     = d3;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [DATA-1:0] act,
                              input logic [DATA-1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Lane i of a write group carries base + i so order can be traced through the queue.
  task automatic apply_stimulus(input logic [IN-1:0] wv, input logic [DATA-1:0] base,
                                input logic [OUT-1:0] ack);
    q_if.wr_valid = wv;
    for (int i = 0; i < IN; i++) begin
      q_if.wr_data[i] = base + DATA'(i);
    end
    q_if.rd_ack = ack;
    @(posedge clk);
    @(negedge clk);
    q_if.wr_valid = '0;
    q_if.rd_ack   = '0;
  endtask

  task automatic check_vector(input int idx, input vec_t v);
    string tag;
    vectors++;
    tag = $sformatf("v%0d", idx);
    check_output({tag, ".count"}, DATA'(q_if.count), DATA'(v.cnt));
    check_output({tag, ".rd_valid"}, DATA'(q_if.rd_valid), DATA'(v.rdv));
    check_output({tag, ".wr_ready"}, DATA'(q_if.wr_ready), DATA'(v.rdy));
    check_output({tag, ".full"}, DATA'(q_if.full), DATA'(v.full));
    check_output({tag, ".empty"}, DATA'(q_if.empty), DATA'(v.empty));
    for (int j = 0; j < OUT; j++) begin
      if (v.rdv[j]) begin
        check_output($sformatf("%s.rd_data[%0d]", tag, j), q_if.rd_data[j], v.d[j]);
      end
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    q_if.wr_valid = '0;
    q_if.wr_data  = '0;
    q_if.rd_ack   = '0;

    vecs[0]  = mk(8'h07, 32'hA0, 4'h0, 5'd3,  4'h7, 1, 0, 0, 32'hA0, 32'hA1, 32'hA2, 32'h0);
    vecs[1]  = mk(8'h00, 32'h00, 4'h0, 5'd3,  4'h7, 1, 0, 0, 32'hA0, 32'hA1, 32'hA2, 32'h0);
    vecs[2]  = mk(8'h1F, 32'hB0, 4'h0, 5'd8,  4'hF, 1, 0, 0, 32'hA0, 32'hA1, 32'hA2, 32'hB0);
    vecs[3]  = mk(8'hFF, 32'hC0, 4'h0, 5'd16, 4'hF, 0, 1, 0, 32'hA0, 32'hA1, 32'hA2, 32'hB0);
    vecs[4]  = mk(8'hFF, 32'hD0, 4'h0, 5'd16, 4'hF, 0, 1, 0, 32'hA0, 32'hA1, 32'hA2, 32'hB0);
    vecs[5]  = mk(8'h00, 32'h00, 4'h3, 5'd14, 4'hF, 0, 0, 0, 32'hA2, 32'hB0, 32'hB1, 32'hB2);
    vecs[6]  = mk(8'h00, 32'h00, 4'hF, 5'd10, 4'hF, 0, 0, 0, 32'hB3, 32'hB4, 32'hC0, 32'hC1);
    vecs[7]  = mk(8'h00, 32'h00, 4'h3, 5'd8,  4'hF, 1, 0, 0, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    vecs[8]  = mk(8'h0F, 32'hE0, 4'hF, 5'd8,  4'hF, 1, 0, 0, 32'hC4, 32'hC5, 32'hC6, 32'hC7);
    vecs[9]  = mk(8'hFF, 32'hF0, 4'hF, 5'd12, 4'hF, 0, 0, 0, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
    vecs[10] = mk(8'h00, 32'h00, 4'hF, 5'd8,  4'hF, 1, 0, 0, 32'hF0, 32'hF1, 32'hF2, 32'hF3);
    vecs[11] = mk(8'h1F, 32'h50, 4'hF, 5'd9,  4'hF, 0, 0, 0, 32'hF4, 32'hF5, 32'hF6, 32'hF7);
    vecs[12] = mk(8'h00, 32'h00, 4'hF, 5'd5,  4'hF, 1, 0, 0, 32'h50, 32'h51, 32'h52, 32'h53);
    vecs[13] = mk(8'h00, 32'h00, 4'hF, 5'd1,  4'h1, 1, 0, 0, 32'h54, 32'h0,  32'h0,  32'h0);
    vecs[14] = mk(8'h03, 32'h60, 4'h0, 5'd3,  4'h7, 1, 0, 0, 32'h54, 32'h60, 32'h61, 32'h0);
    vecs[15] = mk(8'h00, 32'h00, 4'h1, 5'd2,  4'h3, 1, 0, 0, 32'h60, 32'h61, 32'h0,  32'h0);
    vecs[16] = mk(8'h00, 32'h00, 4'hF, 5'd0,  4'h0, 1, 0, 1, 32'h0,  32'h0,  32'h0,  32'h0);

    repeat (2) @(negedge clk);
    vectors++;
    check_output("reset.count", DATA'(q_if.count), 32'd0);
    check_output("reset.rd_valid", DATA'(q_if.rd_valid), 32'd0);
    check_output("reset.wr_ready", DATA'(q_if.wr_ready), 32'd1);
    check_output("reset.full", DATA'(q_if.full), 32'd0);
    check_output("reset.empty", DATA'(q_if.empty), 32'd1);
    reset = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      apply_stimulus(vecs[k].wr_valid, vecs[k].base, vecs[k].ack);
      check_vector(k, vecs[k]);
    end

    // Reset mid-burst: queue fills, then reset discards everything at once.
    apply_stimulus(8'hFF, 32'h70, 4'h0);
    vectors++;
    check_output("burst.count", DATA'(q_if.count), 32'd8);
    check_output("burst.rd_data[0]", q_if.rd_data[0], 32'h70);

    q_if.wr_valid = 8'h1F;
    for (int i = 0; i < IN; i++) begin
      q_if.wr_data[i] = 32'h80 + DATA'(i);
    end
    q_if.rd_ack = 4'hF;
    reset = 1'b1;
    #1;
    vectors++;
    check_output("midreset.count", DATA'(q_if.count), 32'd0);
    check_output("midreset.rd_valid", DATA'(q_if.rd_valid), 32'd0);
    check_output("midreset.wr_ready", DATA'(q_if.wr_ready), 32'd1);
    check_output("midreset.empty", DATA'(q_if.empty), 32'd1);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    check_output("heldreset.count", DATA'(q_if.count), 32'd0);
    reset = 1'b0;

    apply_stimulus(8'h01, 32'h90, 4'h0);
    vectors++;
    check_output("postreset.count", DATA'(q_if.count), 32'd1);
    check_output("postreset.rd_valid", DATA'(q_if.rd_valid), 32'd1);
    check_output("postreset.rd_data[0]", q_if.rd_data[0], 32'h90);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
